potential_decay_engine: RTL and testbench
=========================================

// Module: potential_decay_engine
// PURPOSE
//  Sweeps the FP32 membrane potentials of NUM_NEURONS neurons once per timestep: read, decay, write back.
//  Successor to the single-neuron decay unit, generalised in neuron count, rate width and model set.
//  Pipelined to one neuron per cycle. Sits between the timestep controller and the neuron potential RAM.
//  The RAM is dual-port with a 1-cycle read latency.
// PARAMETERS
//  NUM_NEURONS  16  neurons swept per pass (>=1)
//  ADDR_W       4   potential RAM address width; 2^ADDR_W >= NUM_NEURONS
//  RATE_W       3   width of decay_rate (shift amount on the exponent)
// PORTS
//  CLK         in   1       clock, rising edge
//  RESET_N     in   1       synchronous, active-low reset
//  start       in   1       timestep pulse; begins a pass when idle
//  model       in   2       neuron model; sampled at accepted start
//  decay_rate  in   RATE_W  decay shift k; sampled at accepted start
//  rd_en       out  1       RAM read strobe
//  rd_addr     out  ADDR_W  RAM read address
//  rd_data     in   32      FP32 potential; valid the cycle after rd_en
//  wr_en       out  1       RAM write strobe
//  wr_addr     out  ADDR_W  RAM write address
//  wr_data     out  32      decayed FP32 potential
//  busy        out  1       pass in progress
//  done        out  1       1-cycle pulse when the pass completes
// BEHAVIOUR
//  Clock, reset and registers
//   - One clock, CLK. RESET_N is synchronous and active-low.
//   - All outputs are registered.
//   - Reset: every output is 0, state is IDLE, and all counters and sampled config regs are 0.
//  FSM states: IDLE, RUN, DRAIN, DONE
//   - IDLE -> RUN: start=1 accepted at edge 0 (the capturing edge); model and decay_rate are latched.
//   - RUN: rd_en=1 and rd_addr=0..NUM_NEURONS-1, one address per cycle from cycle 1 to cycle NUM_NEURONS.
//   - RUN -> DRAIN: after rd_addr=NUM_NEURONS-1 is issued.
//   - DRAIN: lasts 2 cycles; rd_en=0 while in-flight writes complete.
//   - DONE: done=1 for 1 cycle at cycle NUM_NEURONS+3, then the FSM returns to IDLE.
//   - busy=1 from cycle 1 through cycle NUM_NEURONS+2.
//  Write timing
//   - Data for address a arrives one cycle after its read.
//   - wr_en/wr_addr=a/wr_data are registered from that data and asserted 2 cycles after the read of a.
//   - Throughput is 1 neuron/cycle. Latency from start to done is NUM_NEURONS+3 cycles.
//  Control inputs
//   - start while busy or in DONE is ignored. It is not queued.
//   - Changes to model or decay_rate mid-pass have no effect.
//  Decay arithmetic: V = {s, e[7:0], m[22:0]}, k = latched decay_rate
//   - 2'b00 LIF: out = V*2^-k by exponent subtraction.
//   - 2'b01 IZH: out = V unchanged. Its dynamics live elsewhere.
//   - 2'b10 clamped LIF: if s=1 then out=+0, else as LIF.
//   - 2'b11 reserved: pass-through.
//  Special cases, for every model that decays
//   - e==255 (Inf/NaN): passed unchanged.
//   - e==0 (zero/denormal): out = 32'h0000_0000 (+0).
//   - 0 < e <= k (underflow): out = +0. There is no denormal generation.
//   - k==0: out = V.
//   - No rounding; the mantissa is never modified.
//  Reset mid-pass
//   - RESET_N=0 at any edge: wr_en, rd_en, busy and done are 0 after that edge; the FSM goes to IDLE.
//   - No further writes occur and no done is issued.
//  NUM_NEURONS=1: a single read at cycle 1, write at cycle 3, done at cycle 4.
// TESTING
//  Bench: NUM_NEURONS=16; 1-cycle-latency RAM model; all RAM words loaded with the listed V.
//  1. model=00, k=1, V=32'h41200000 (10.0)
//     -> every word becomes 32'h40A00000 (5.0).
//     -> 16 writes on cycles 3..18, done on cycle 19, busy high on cycles 1..18.
//  2. model=00, k=3, V=32'hC1200000 (-10.0) -> 32'hBFA00000 (-1.25).
//     Also, with k=0: V is unchanged.
//  3. model=00, k=1:
//     - 32'h00800000 -> 32'h00000000.
//     - 32'h7FC00000 (NaN) -> unchanged.
//     - 32'h7F800000 (Inf) -> unchanged.
//  4. model=01, k=7: 32'h41200000 -> unchanged.
//     model=10, k=1: 32'hC1200000 -> 32'h00000000, and 32'h41200000 -> 32'h40A00000.
//  5. start pulsed again at cycle 5 of a pass -> ignored: exactly 16 writes and one done.
//     A fresh start after done -> a second full pass.
//  6. RESET_N=0 at cycle 6 of a pass
//     -> wr_en, rd_en and busy are 0 from the next edge, no done, FSM idle.
//     -> A later start runs a full pass from address 0.

Source files
------------

// File: rtl/potential_decay_engine.sv
// -----------------------------------------------------------------------------
// potential_decay_engine
//
// Sweeps the FP32 membrane potentials of NUM_NEURONS neurons once per
// timestep: each word is read from the potential RAM, decayed according to the
// selected neuron model, and written back. One neuron is processed per cycle.
//
// Timeline of one pass (cycle n = the interval after rising edge n, where
// edge 0 is the edge that accepts start):
//   cycles 1..N      rd_en=1, rd_addr = 0..N-1
//   cycles 3..N+2    wr_en=1, wr_addr = 0..N-1 (two cycles behind the read)
//   cycles 1..N+2    busy=1
//   cycle  N+3       done=1
//
// Ports
//   CLK         in   clock, rising edge
//   RESET_N     in   synchronous, active-low reset
//   start       in   timestep pulse; begins a pass when idle
//   model       in   neuron model (00 LIF, 01 IZH, 10 clamped LIF, 11 reserved)
//   decay_rate  in   exponent shift k, sampled with model at accepted start
//   rd_en       out  RAM read strobe
//   rd_addr     out  RAM read address
//   rd_data     in   FP32 potential, valid the cycle after rd_en
//   wr_en       out  RAM write strobe
//   wr_addr     out  RAM write address
//   wr_data     out  decayed FP32 potential
//   busy        out  pass in progress
//   done        out  one-cycle pulse at the end of a pass
// -----------------------------------------------------------------------------
module potential_decay_engine #(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = 4,
  parameter int RATE_W      = 3
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic [1:0]        model,
  input  logic [RATE_W-1:0] decay_rate,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

  // Exponent/shift comparisons are done at a width that holds both an 8-bit
  // exponent and the full shift amount, so large k never wraps.
  localparam int CW = (RATE_W > 8) ? RATE_W : 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_cnt_reg;
  logic              drain_cnt_reg;
  logic [1:0]        model_reg;
  logic [RATE_W-1:0] rate_reg;

  // Tracks the read issued last cycle: its data is on rd_data this cycle.
  logic              data_valid_reg;
  logic [ADDR_W-1:0] data_addr_reg;

  // ---------------------------------------------------------------------------
  // Decay arithmetic on the word currently returned by the RAM
  // ---------------------------------------------------------------------------
  logic          sign_bit;
  logic [7:0]    exp_field;
  logic [CW-1:0] exp_w;
  logic [CW-1:0] k_w;
  logic [CW-1:0] exp_sub;
  logic [31:0]   lif_val;
  logic [31:0]   decayed;

  always_comb begin
    sign_bit  = rd_data[31];
    exp_field = rd_data[30:23];
    exp_w     = CW'(exp_field);
    k_w       = CW'(rate_reg);
    exp_sub   = exp_w - k_w;

    // Multiplying by 2^-k only touches the exponent; the mantissa is kept.
    lif_val = {sign_bit, exp_sub[7:0], rd_data[22:0]};
    if (exp_field == 8'hFF) begin
      lif_val = rd_data;          // Inf / NaN pass through
    end else if (exp_field == 8'h00) begin
      lif_val = 32'h0000_0000;    // zero and denormals flush to +0
    end else if (k_w == '0) begin
      lif_val = rd_data;
    end else if (exp_w <= k_w) begin
      lif_val = 32'h0000_0000;    // would underflow; no denormal generation
    end

    decayed = rd_data;
    case (model_reg)
      2'b00: decayed = lif_val;
      // Clamped LIF forces negative finite potentials to +0; Inf/NaN are
      // still left untouched like every other decaying model.
      2'b10: decayed = (sign_bit && (exp_field != 8'hFF)) ? 32'h0000_0000 : lif_val;
      default: decayed = rd_data; // IZH and reserved leave the word alone
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM, read issue and write-back pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg      <= IDLE;
      addr_cnt_reg   <= '0;
      drain_cnt_reg  <= 1'b0;
      model_reg      <= 2'b00;
      rate_reg       <= '0;
      data_valid_reg <= 1'b0;
      data_addr_reg  <= '0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;

      // Stage 1: remember which read is now returning data.
      data_valid_reg <= rd_en;
      data_addr_reg  <= rd_addr;

      // Stage 2: register the decayed word as the write-back.
      wr_en <= data_valid_reg;
      if (data_valid_reg) begin
        wr_addr <= data_addr_reg;
        wr_data <= decayed;
      end

      case (state_reg)
        IDLE: begin
          // The done pulse cycle still counts as the end of the previous
          // pass, so a start arriving alongside it is dropped.
          if (start && !done) begin
            state_reg    <= RUN;
            model_reg    <= model;
            rate_reg     <= decay_rate;
            addr_cnt_reg <= '0;
          end
        end

        RUN: begin
          rd_en   <= 1'b1;
          rd_addr <= addr_cnt_reg;
          busy    <= 1'b1;
          if (addr_cnt_reg == LAST_ADDR) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= 1'b0;
          end else begin
            addr_cnt_reg <= addr_cnt_reg + 1'b1;
          end
        end

        DRAIN: begin
          // Two cycles let the last read return and its write be issued.
          drain_cnt_reg <= 1'b1;
          if (drain_cnt_reg) begin
            state_reg <= DONE;
          end
        end

        DONE: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_potential_decay_engine.sv
// -----------------------------------------------------------------------------
// Bench for potential_decay_engine. A 1-cycle-latency dual-port RAM model
// feeds the DUT. Each pass pushes the expected writes (address, data, cycle)
// into a queue; a monitor pops and compares whenever wr_en is seen. Pass-level
// properties (done timing, busy window, write count, final RAM image) are
// checked after each pass.
// -----------------------------------------------------------------------------
module tb_potential_decay_engine;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int RW = 3;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    model = 2'b00;
  logic [RW-1:0] decay_rate = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data = 32'h0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;

  potential_decay_engine #(.NUM_NEURONS(N), .ADDR_W(AW), .RATE_W(RW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .model(model),
    .decay_rate(decay_rate), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // RAM model: 1-cycle read latency, plus a bench load port.
  logic [31:0]   mem [N];
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = 32'h0;

  always @(posedge CLK) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    if (load_en) mem[load_addr] <= load_data;
  end

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Scoreboard state
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] model_mem [N];   // what the RAM should hold
  logic [31:0] fill_val  [N];

  int checks = 0;
  int errors = 0;
  int t0 = 0;
  int wr_cnt, done_cnt, done_cyc, busy_first, busy_last, busy_cnt;

  // Reference: value after one decay step, from the model rules directly.
  function automatic logic [31:0] ref_decay(input logic [31:0] v, input logic [1:0] m, input int k);
    int e;
    e = int'(v[30:23]);
    if (m == 2'b01 || m == 2'b11) return v;
    if (e == 255) return v;
    if (m == 2'b10 && v[31]) return 32'h0;
    if (e == 0) return 32'h0;
    if (k == 0) return v;
    if (e <= k) return 32'h0;
    return v - (32'(k) << 23);
  endfunction

  function automatic logic [31:0] rand_word(input logic [1:0] m, input int k);
    int sel, e;
    logic s;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       e = 255;
      1:       e = (k > 0) ? 0 : 1;
      2, 3:    e = $urandom_range(1, k + 1);
      default: e = $urandom_range(1, 254);
    endcase
    s = 1'($urandom_range(0, 1));
    if (e == 255 && m == 2'b10) s = 1'b0;
    return {s, 8'(e), 23'($urandom)};
  endfunction

  // Monitor: pops an expected write each time the DUT writes.
  always @(negedge CLK) begin
    int c;
    exp_t e;
    c = edge_cnt - t0;
    if (wr_en) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0d data=%h cycle=%0d, required no write",
                 wr_addr, wr_data, c);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || c != e.cyc) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                   wr_addr, wr_data, c, e.addr, e.data, e.cyc);
        end else begin
          $display("write addr=%0d data=%h cycle=%0d ok", wr_addr, wr_data, c);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = c;
    end
    if (busy) begin
      if (busy_first < 0) busy_first = c;
      busy_last = c;
      busy_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fill_ram();
    for (int i = 0; i < N; i++) begin
      @(negedge CLK);
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = fill_val[i];
      model_mem[i] = fill_val[i];
    end
    @(negedge CLK);
    load_en = 1'b0;
  endtask

  // One pass. restart_cyc >= 0 pulses start mid-pass; reset_cyc >= 3 drives
  // RESET_N low during that cycle and checks the abort.
  task automatic run_pass(input logic [1:0] m, input int k, input int restart_cyc, input int reset_cyc);
    int   nexp;
    exp_t e;
    nexp = (reset_cyc >= 0) ? reset_cyc - 2 : N;
    for (int a = 0; a < nexp; a++) begin
      e.addr = AW'(a);
      e.data = ref_decay(model_mem[a], m, k);
      e.cyc  = a + 3;
      exp_q.push_back(e);
      model_mem[a] = e.data;
    end
    $display("pass model=%0d k=%0d restart=%0d reset=%0d", m, k, restart_cyc, reset_cyc);
    @(negedge CLK);
    model      = m;
    decay_rate = RW'(k);
    start      = 1'b1;
    @(posedge CLK);
    t0 = edge_cnt + 1;
    wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    busy_first = -1; busy_last = -1; busy_cnt = 0;
    @(negedge CLK);
    // Config changes after acceptance must be ignored.
    model      = ~m;
    decay_rate = ~RW'(k);
    for (int c = 0; c < 40; c++) begin
      start = (c == restart_cyc);
      if (reset_cyc >= 0) begin
        if (c == reset_cyc) RESET_N = 1'b0;
        if (c == reset_cyc + 1)
          chk("reset_abort_outputs", {60'h0, rd_en, wr_en, busy, done}, 64'h0);
        if (c == reset_cyc + 2) RESET_N = 1'b1;
      end
      @(negedge CLK);
    end
    start = 1'b0;
    if (reset_cyc < 0) begin
      chk("done_count", done_cnt, 1);
      chk("done_cycle", done_cyc, N + 3);
      chk("busy_first_cycle", busy_first, 1);
      chk("busy_last_cycle", busy_last, N + 2);
      chk("busy_cycles", busy_cnt, N + 2);
    end else begin
      chk("done_after_reset", done_cnt, 0);
    end
    chk("write_count", wr_cnt, nexp);
    chk("queue_left", exp_q.size(), 0);
    exp_q.delete();
    begin
      int bad;
      bad = -1;
      for (int i = 0; i < N; i++)
        if (bad < 0 && mem[i] !== model_mem[i]) bad = i;
      if (bad >= 0)
        chk("ram_image", {32'h0, mem[bad]}, {32'h0, model_mem[bad]});
      else
        chk("ram_image", 64'h0, {32'h0, mem[0] ^ model_mem[0]});
    end
  endtask

  initial begin
    logic [1:0] rm;
    int         rk;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data},
        '0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // 1: LIF k=1 on 10.0
    for (int i = 0; i < N; i++) fill_val[i] = 32'h4120_0000;
    fill_ram();
    run_pass(2'b00, 1, -1, -1);
    chk("lif_10_to_5", {32'h0, mem[7]}, 64'h40A0_0000);

    // 2: LIF k=3 on -10.0, then k=0 leaves the result alone
    for (int i = 0; i < N; i++) fill_val[i] = 32'hC120_0000;
    fill_ram();
    run_pass(2'b00, 3, -1, -1);
    chk("lif_neg10_k3", {32'h0, mem[0]}, 64'hBFA0_0000);
    run_pass(2'b00, 0, -1, -1);
    chk("lif_k0_unchanged", {32'h0, mem[15]}, 64'hBFA0_0000);

    // 3: underflow and specials
    for (int i = 0; i < N; i++)
      fill_val[i] = (i % 3 == 0) ? 32'h0080_0000 : (i % 3 == 1) ? 32'h7FC0_0000 : 32'h7F80_0000;
    fill_ram();
    run_pass(2'b00, 1, -1, -1);

    // 4: IZH pass-through, clamped LIF
    for (int i = 0; i < N; i++) fill_val[i] = 32'h4120_0000;
    fill_ram();
    run_pass(2'b01, 7, -1, -1);
    for (int i = 0; i < N; i++) fill_val[i] = (i % 2 == 0) ? 32'hC120_0000 : 32'h4120_0000;
    fill_ram();
    run_pass(2'b10, 1, -1, -1);
    chk("clamp_neg", {32'h0, mem[2]}, 64'h0);
    chk("clamp_pos", {32'h0, mem[3]}, 64'h40A0_0000);

    // 5: start mid-pass ignored, then a fresh pass
    for (int i = 0; i < N; i++) fill_val[i] = rand_word(2'b00, 2);
    fill_ram();
    run_pass(2'b00, 2, 5, -1);
    run_pass(2'b00, 1, -1, -1);

    // 6: reset mid-pass, then a full pass from address 0
    for (int i = 0; i < N; i++) fill_val[i] = rand_word(2'b00, 1);
    fill_ram();
    run_pass(2'b00, 1, -1, 6);
    run_pass(2'b00, 1, -1, -1);

    // Randomized passes
    for (int p = 0; p < 6; p++) begin
      rm = 2'($urandom_range(0, 3));
      rk = $urandom_range(0, 7);
      for (int i = 0; i < N; i++) fill_val[i] = rand_word(rm, rk);
      fill_ram();
      run_pass(rm, rk, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
